// File: rtl/fetch_decode_stage.sv
// Fetch stage of the 5-stage RV32I pipeline: program counter, PC+4 adder and the
// IF/ID pipeline register feeding decode.
module fetch_decode_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic [WIDTH-1:0] PCF,
  input  logic [31:0]      InstrF,
  output logic [31:0]      InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] PCPlus4F;
  logic [WIDTH-1:0] PCNext;

  // Wraps silently at the top of the address space.
  assign PCPlus4F = PCF + PC_STEP;

  // A resolved redirect wins over a fetch stall; the target is word-aligned by
  // dropping its low bits rather than trapping.
  always_comb begin
    PCNext = PCPlus4F;
    if (PCSrcE) begin
      PCNext = {PCTargetE[WIDTH-1:2], 2'b00};
    end else if (StallF) begin
      PCNext = PCF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF <= RESET_PC;
    end else begin
      PCF <= PCNext;
    end
  end

  // Flush wins over stall so a squashed slot can never be held as valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= InstrF;
      PCD      <= PCF;
      PCPlus4D <= PCPlus4F;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: free-run, stall, redirect, priority,
// address wrap and asynchronous reset, with hand-computed expectations.
module tb_fetch_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int vecCount = 0;
  int missCount = 0;

  fetch_decode_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StallF   (StallF),
    .StallD   (StallD),
    .FlushD   (FlushD),
    .PCSrcE   (PCSrcE),
    .PCTargetE(PCTargetE),
    .PCF      (PCF),
    .InstrF   (InstrF),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: two fixed words, everything else a tag of its address.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h00A0_0093;
    if (addr == 32'h4) return 32'h0010_0113;
    return addr ^ 32'hA5A5_0000;
  endfunction

  assign InstrF = imem(PCF);

  always @(negedge clk) begin
    if (rst_n && StallF && !StallD && !FlushD)
      $display("warning: illegal stimulus StallF without StallD at t=%0t", $time);
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setCtl(input logic sf, input logic sd, input logic fd,
                        input logic ps, input logic [31:0] tgt);
    StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] eInstr,
                           input logic [31:0] ePc, input logic [31:0] ePc4,
                           input logic eValid);
    checkVal({tag, ".InstrD"}, InstrD, eInstr);
    checkVal({tag, ".PCD"}, PCD, ePc);
    checkVal({tag, ".PCPlus4D"}, PCPlus4D, ePc4);
    checkVal({tag, ".ValidD"}, {31'b0, ValidD}, {31'b0, eValid});
  endtask

  initial begin
    rst_n = 1'b0;
    setCtl(0, 0, 0, 0, 32'h0);
    #12;
    checkVal("rst.PCF", PCF, 32'h0);
    checkIfId("rst", NOP, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;

    // Free run
    step();
    checkVal("run1.PCF", PCF, 32'h4);
    checkIfId("run1", 32'h00A0_0093, 32'h0, 32'h4, 1'b1);
    step();
    checkVal("run2.PCF", PCF, 32'h8);
    checkIfId("run2", 32'h0010_0113, 32'h4, 32'h8, 1'b1);

    // Load-use stall at PCF=8
    setCtl(1, 1, 0, 0, 32'h0);
    step();
    checkVal("stall.PCF", PCF, 32'h8);
    checkIfId("stall", 32'h0010_0113, 32'h4, 32'h8, 1'b1);
    setCtl(0, 0, 0, 0, 32'h0);
    step();
    checkVal("resume.PCF", PCF, 32'hC);
    checkIfId("resume", imem(32'h8), 32'h8, 32'hC, 1'b1);
    step();
    checkVal("pre_redir.PCF", PCF, 32'h10);

    // Redirect with flush
    setCtl(0, 0, 1, 1, 32'h0000_0100);
    step();
    checkVal("redir.PCF", PCF, 32'h100);
    checkIfId("redir", NOP, 32'h0, 32'h0, 1'b0);
    setCtl(0, 0, 0, 0, 32'h0);
    step();
    checkVal("redir2.PCF", PCF, 32'h104);
    checkIfId("redir2", imem(32'h100), 32'h100, 32'h104, 1'b1);

    // Redirect beats StallF, flush beats StallD, low target bits dropped
    setCtl(1, 1, 1, 1, 32'h0000_0203);
    step();
    checkVal("prio.PCF", PCF, 32'h200);
    checkIfId("prio", NOP, 32'h0, 32'h0, 1'b0);
    setCtl(0, 0, 0, 0, 32'h0);
    step();
    checkVal("prio2.PCF", PCF, 32'h204);
    checkIfId("prio2", imem(32'h200), 32'h200, 32'h204, 1'b1);

    // Address wrap
    setCtl(0, 0, 1, 1, 32'hFFFF_FFFC);
    step();
    checkVal("wrap0.PCF", PCF, 32'hFFFF_FFFC);
    setCtl(0, 0, 0, 0, 32'h0);
    step();
    checkVal("wrap.PCF", PCF, 32'h0);
    checkIfId("wrap", imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Asynchronous reset mid-run at PCF=0x40
    setCtl(0, 0, 1, 1, 32'h0000_003C);
    step();
    setCtl(0, 0, 0, 0, 32'h0);
    step();
    checkVal("pre_arst.PCF", PCF, 32'h40);
    checkIfId("pre_arst", imem(32'h3C), 32'h3C, 32'h40, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst.PCF", PCF, 32'h0);
    checkIfId("arst", NOP, 32'h0, 32'h0, 1'b0);
    step();
    checkVal("arst_hold.PCF", PCF, 32'h0);
    checkVal("arst_hold.ValidD", {31'b0, ValidD}, 32'h0);
    #2;
    rst_n = 1'b1;
    step();
    checkVal("rerun.PCF", PCF, 32'h4);
    checkIfId("rerun", 32'h00A0_0093, 32'h0, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
